divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/div_pkg.sv | 13 +
 rtl/divider_if.sv | 24 ++
 rtl/div_step.sv | 30 +++
 rtl/divider.sv | 88 ++++++++
 tb/tb_divider.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared FSM encodings for the restoring divider.
// Latency: none (types only).
// Backpressure: none (types only).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
// Latency: none (wires only).
// Backpressure: none; start is only sampled while the divider is idle.
interface divider_if #(
    parameter int N = 4
);
    logic         start;
    logic         ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, restore on borrow.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   i_r,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_d,
    output logic [N:0]   o_r,
    output logic [N-1:0] o_q
);
    logic [2*N:0] w_sh;
    logic [N:0]   w_r_sh;
    logic [N:0]   w_trial;

    assign w_sh    = {i_r, i_q} << 1;
    assign w_r_sh  = w_sh[2*N:N];
    assign w_trial = w_r_sh - {1'b0, i_d};

    // Keep the trial difference only when it did not borrow (sign bit clear).
    always_comb begin
        o_r = w_r_sh;
        o_q = w_sh[N-1:0];
        if (!w_trial[N]) begin
            o_r    = w_trial;
            o_q[0] = 1'b1;
        end
    end
endmodule

// File: rtl/divider.sv
// Unsigned N-bit restoring divider; DIVIDER_ZERO_CHECK_EN adds a divide-by-zero shortcut and flag.
// Latency: N+2 cycles from the start edge to ready (2 cycles for a zero divisor with the shortcut).
// Backpressure: start is ignored while busy; ready is a one-cycle pulse, results hold until next DONE.
module divider
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    state_t        r_state;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_d;
    logic [CW-1:0] r_cnt;
    logic          r_dz;

    logic [N:0]    w_rem_nxt;
    logic [N-1:0]  w_q_nxt;

    div_step #(.N(N)) u_step (
        .i_r (r_rem),
        .i_q (r_q),
        .i_d (r_d),
        .o_r (w_rem_nxt),
        .o_q (w_q_nxt)
    );

    // Control FSM with datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_rem           <= '0;
            r_q             <= '0;
            r_d             <= '0;
            r_cnt           <= '0;
            r_dz            <= 1'b0;
            bus.ready       <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // Operands are captured here; later changes on the bus are ignored.
                    r_q   <= bus.dividend;
                    r_d   <= bus.divisor;
                    r_rem <= '0;
                    r_cnt <= CW'(N);
`ifdef DIVIDER_ZERO_CHECK_EN
                    r_dz    <= (bus.divisor == '0);
                    r_state <= (bus.divisor == '0) ? DONE : EXEC;
`else
                    r_dz    <= 1'b0;
                    r_state <= EXEC;
`endif
                end
                EXEC: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // On the shortcut path r_q still holds the untouched dividend.
                    bus.quotient    <= r_dz ? '1 : r_q;
                    bus.remainder   <= r_dz ? r_q : r_rem[N-1:0];
                    bus.div_by_zero <= r_dz;
                    bus.ready       <= 1'b1;
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider at N=4 and N=8.
// Latency: checks ready timing relative to the edge that samples start.
// Backpressure: exercises start held high, toggled mid-operation, and reset aborts.
module tb_divider;
    import div_pkg::*;

`ifdef DIVIDER_ZERO_CHECK_EN
    localparam int unsigned ZDZ  = 1;
    localparam int unsigned ZLAT = 2;
`else
    localparam int unsigned ZDZ  = 0;
    localparam int unsigned ZLAT = 6;
`endif

    logic        clk;
    logic        rst_n;
    int unsigned cyc      = 0;
    int unsigned rdy_cnt4 = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    divider_if #(.N(4)) if4 ();
    divider_if #(.N(8)) if8 ();

    divider #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    divider #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure latency from the start-sampling edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Count ready pulses of the N=4 instance to catch spurious or missing completions.
    always @(negedge clk) if (if4.ready) rdy_cnt4 = rdy_cnt4 + 1;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit rdy(input bit w8);
        return w8 ? if8.ready : if4.ready;
    endfunction

    function automatic int unsigned quo(input bit w8);
        return w8 ? int'(if8.quotient) : int'(if4.quotient);
    endfunction

    function automatic int unsigned rem(input bit w8);
        return w8 ? int'(if8.remainder) : int'(if4.remainder);
    endfunction

    function automatic int unsigned dz(input bit w8);
        return w8 ? int'(if8.div_by_zero) : int'(if4.div_by_zero);
    endfunction

    task automatic set_in(input bit w8, input int unsigned a, input int unsigned b, input bit s);
        if (w8) begin
            if8.dividend = a[7:0];
            if8.divisor  = b[7:0];
            if8.start    = s;
        end else begin
            if4.dividend = a[3:0];
            if4.divisor  = b[3:0];
            if4.start    = s;
        end
    endtask

    // Waits for ready; returns the edge index at which it rose, or flags a timeout.
    task automatic wait_rdy(input bit w8, input int budget, input string tag, output int unsigned at);
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rdy(w8)) begin
                at = cyc;
                return;
            end
        end
        check({tag, "_timeout"}, rdy(w8), 1);
    endtask

    // Called at a negedge: pulses start, checks latency, results and single-cycle ready.
    task automatic do_div(input bit w8, input int unsigned a, input int unsigned b,
                          input int unsigned eq, input int unsigned er, input int unsigned edz,
                          input int unsigned elat, input string tag);
        int unsigned c0;
        int unsigned at;
        set_in(w8, a, b, 1'b1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        set_in(w8, a, b, 1'b0);
        wait_rdy(w8, 20, tag, at);
        check({tag, "_lat"}, at - c0, elat);
        check({tag, "_q"}, quo(w8), eq);
        check({tag, "_r"}, rem(w8), er);
        check({tag, "_dz"}, dz(w8), edz);
        @(posedge clk);
        #1;
        check({tag, "_rdy_off"}, rdy(w8), 0);
        check({tag, "_q_hold"}, quo(w8), eq);
        @(negedge clk);
    endtask

    initial begin
        int unsigned c0;
        int unsigned at;
        int unsigned rc;
        int unsigned t [3];

        rst_n = 1'b0;
        set_in(1'b0, 0, 0, 1'b0);
        set_in(1'b1, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", rdy(0), 0);
        check("rst_q", quo(0), 0);
        check("rst_r", rem(0), 0);
        check("rst_dz", dz(0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(1'b0, 13, 3, 4, 1, 0, 6, "d13_3");
        do_div(1'b0, 15, 1, 15, 0, 0, 6, "d15_1");
        do_div(1'b0, 5, 7, 0, 5, 0, 6, "d5_7");
        do_div(1'b1, 255, 16, 15, 15, 0, 10, "w255_16");
        do_div(1'b0, 9, 0, 15, 9, ZDZ, ZLAT, "d9_0");
        do_div(1'b0, 6, 2, 3, 0, 0, 6, "d6_2_dzclr");

        // Start toggled and operands changed after capture; result must be unaffected.
        #1 rc = rdy_cnt4;
        set_in(1'b0, 13, 3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        if4.start = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if4.start    = (i != 1);
            if4.dividend = 4'(2 + i);
            if4.divisor  = 4'd1;
        end
        @(negedge clk);
        if4.start = 1'b0;
        wait_rdy(1'b0, 20, "tog", at);
        check("tog_lat", at - c0, 6);
        check("tog_q", quo(0), 4);
        check("tog_r", rem(0), 1);
        repeat (12) @(posedge clk);
        #1;
        check("tog_pulses", rdy_cnt4 - rc, 1);
        @(negedge clk);

        // Reset during EXEC aborts silently; the first post-reset edge accepts start.
        set_in(1'b0, 13, 3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rc = rdy_cnt4;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_rdy", rdy(0), 0);
        check("abort_q", quo(0), 0);
        check("abort_r", rem(0), 0);
        check("abort_dz", dz(0), 0);
        rst_n = 1'b1;
        do_div(1'b0, 12, 5, 2, 2, 0, 6, "d12_5");
        #1;
        check("abort_pulses", rdy_cnt4 - rc, 1);
        @(negedge clk);

        // Start held high: back-to-back completions every N+3 edges.
        set_in(1'b0, 13, 3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_rdy(1'b0, 20, "b2b", t[i]);
            check("b2b_q", quo(0), 4);
            check("b2b_r", rem(0), 1);
        end
        if4.start = 1'b0;
        check("b2b_first", t[0] - c0, 6);
        check("b2b_gap1", t[1] - t[0], 7);
        check("b2b_gap2", t[2] - t[1], 7);
        repeat (12) @(posedge clk);
        #1;
        check("b2b_idle", rdy(0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
